// File: rtl/fifo_wr_ctrl_if.sv
// Write-side port bundle of the async FIFO: producer handshake, synchronised
// read pointer in, and the write pointer/status/memory strobes out.
interface fifo_wr_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  winc;
    logic                  wclr_ovf;
    logic [ADDR_WIDTH:0]   wq2_rptr;
    logic                  wfull;
    logic                  wafull;
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  wen;
    logic [ADDR_WIDTH:0]   wlevel;
    logic                  woverflow;

    modport master (
        output winc, wclr_ovf, wq2_rptr,
        input  wfull, wafull, wptr, waddr, wen, wlevel, woverflow
    );

    modport slave (
        input  winc, wclr_ovf, wq2_rptr,
        output wfull, wafull, wptr, waddr, wen, wlevel, woverflow
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of an async FIFO: binary/Gray write pointer, full and
// almost-full detection against the synchronised Gray read pointer, sticky overflow.
module fifo_wr_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic           wclk,
    input  logic           wrst_n,
    fifo_wr_ctrl_if.slave  bus
);
    localparam int unsigned PW = ADDR_WIDTH + 1;
    // Full when the Gray pointers differ only in their top two bits.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    logic [PW-1:0]         wbin;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic                  ovf_q;
    logic [PW-1:0]         gray_w;
    logic [PW-1:0]         rbin;
    logic [PW-1:0]         level;
    logic                  full;
    logic                  wen_int;

    // Read pointer arrives only in Gray form; decode it by prefix-XOR from the MSB.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < int'(PW); i++) begin
            rbin[i] = ^(bus.wq2_rptr >> i);
        end
    end

    always_comb begin
        gray_w  = wbin ^ (wbin >> 1);
        full    = (gray_w == (bus.wq2_rptr ^ FULL_MASK));
        wen_int = bus.winc & ~full;
        level   = wbin - rbin;
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin    <= '0;
            waddr_q <= '0;
        end else if (wen_int) begin
            wbin    <= wbin + PW'(1);
            waddr_q <= waddr_q + ADDR_WIDTH'(1);
        end
    end

    // Sticky overflow; a new overflow outranks a clear in the same cycle.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            ovf_q <= 1'b0;
        end else if (bus.winc && full) begin
            ovf_q <= 1'b1;
        end else if (bus.wclr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.wptr      = gray_w;
    assign bus.waddr     = waddr_q;
    assign bus.wfull     = full;
    assign bus.wen       = wen_int;
    assign bus.wlevel    = level;
    assign bus.wafull    = (level >= PW'(AFULL_THRESH));
    assign bus.woverflow = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: vector table for reset/fill/overflow/drain,
// plus hand sequences for pointer wrap and a reset glitch between edges.
module tb_fifo_wr_ctrl;
    localparam int unsigned AW = 3;

    typedef struct {
        logic       rst_n;
        logic       winc;
        logic       clr;
        logic [3:0] rptr;
        logic [3:0] e_wptr;
        logic [2:0] e_waddr;
        logic [3:0] e_lvl;
        logic       e_full;
        logic       e_afull;
        logic       e_wen;
        logic       e_ovf;
    } vec_t;

    logic wclk = 1'b0;
    logic wrst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl [15];

    always #5 wclk = ~wclk;

    fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(6)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d.wptr", i),  32'(bus.wptr),      32'(v.e_wptr));
        chk($sformatf("v%0d.waddr", i), 32'(bus.waddr),     32'(v.e_waddr));
        chk($sformatf("v%0d.wlevel", i),32'(bus.wlevel),    32'(v.e_lvl));
        chk($sformatf("v%0d.wfull", i), 32'(bus.wfull),     32'(v.e_full));
        chk($sformatf("v%0d.wafull", i),32'(bus.wafull),    32'(v.e_afull));
        chk($sformatf("v%0d.wen", i),   32'(bus.wen),       32'(v.e_wen));
        chk($sformatf("v%0d.wovf", i),  32'(bus.woverflow), 32'(v.e_ovf));
    endtask

    initial begin
        logic [3:0] mb;
        logic [3:0] prev;

        //          rst  inc  clr  rptr     wptr     addr  lvl      full afull wen  ovf
        tbl[0]  = '{1'b0,1'b1,1'b0,4'b0000, 4'b0000, 3'd0, 4'd0, 1'b0,1'b0,1'b1,1'b0};
        tbl[1]  = '{1'b0,1'b1,1'b0,4'b0000, 4'b0000, 3'd0, 4'd0, 1'b0,1'b0,1'b1,1'b0};
        tbl[2]  = '{1'b1,1'b1,1'b0,4'b0000, 4'b0001, 3'd1, 4'd1, 1'b0,1'b0,1'b1,1'b0};
        tbl[3]  = '{1'b1,1'b1,1'b0,4'b0000, 4'b0011, 3'd2, 4'd2, 1'b0,1'b0,1'b1,1'b0};
        tbl[4]  = '{1'b1,1'b1,1'b0,4'b0000, 4'b0010, 3'd3, 4'd3, 1'b0,1'b0,1'b1,1'b0};
        tbl[5]  = '{1'b1,1'b1,1'b0,4'b0000, 4'b0110, 3'd4, 4'd4, 1'b0,1'b0,1'b1,1'b0};
        tbl[6]  = '{1'b1,1'b1,1'b0,4'b0000, 4'b0111, 3'd5, 4'd5, 1'b0,1'b0,1'b1,1'b0};
        tbl[7]  = '{1'b1,1'b1,1'b0,4'b0000, 4'b0101, 3'd6, 4'd6, 1'b0,1'b1,1'b1,1'b0};
        tbl[8]  = '{1'b1,1'b1,1'b0,4'b0000, 4'b0100, 3'd7, 4'd7, 1'b0,1'b1,1'b1,1'b0};
        tbl[9]  = '{1'b1,1'b1,1'b0,4'b0000, 4'b1100, 3'd0, 4'd8, 1'b1,1'b1,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b1,1'b0,4'b0000, 4'b1100, 3'd0, 4'd8, 1'b1,1'b1,1'b0,1'b1};
        tbl[11] = '{1'b1,1'b0,1'b0,4'b0000, 4'b1100, 3'd0, 4'd8, 1'b1,1'b1,1'b0,1'b1};
        tbl[12] = '{1'b1,1'b0,1'b1,4'b0000, 4'b1100, 3'd0, 4'd8, 1'b1,1'b1,1'b0,1'b0};
        tbl[13] = '{1'b1,1'b1,1'b1,4'b0000, 4'b1100, 3'd0, 4'd8, 1'b1,1'b1,1'b0,1'b1};
        tbl[14] = '{1'b1,1'b0,1'b1,4'b0001, 4'b1100, 3'd0, 4'd7, 1'b0,1'b1,1'b0,1'b0};

        wrst_n       = 1'b0;
        bus.winc     = 1'b0;
        bus.wclr_ovf = 1'b0;
        bus.wq2_rptr = 4'b0000;

        for (int i = 0; i < 15; i++) begin
            @(negedge wclk);
            wrst_n       = tbl[i].rst_n;
            bus.winc     = tbl[i].winc;
            bus.wclr_ovf = tbl[i].clr;
            bus.wq2_rptr = tbl[i].rptr;
            @(posedge wclk);
            #1;
            check_vec(i, tbl[i]);
        end

        // Drain unblock continued: the write after the read step lands at address 0
        @(negedge wclk);
        bus.winc     = 1'b1;
        bus.wclr_ovf = 1'b0;
        #1;
        chk("drain.wen", 32'(bus.wen), 32'd1);
        chk("drain.waddr_pre", 32'(bus.waddr), 32'd0);
        @(posedge wclk);
        #1;
        chk("drain.wptr", 32'(bus.wptr), 32'(4'b1101));
        chk("drain.waddr", 32'(bus.waddr), 32'd1);
        chk("drain.wfull", 32'(bus.wfull), 32'd1);
        chk("drain.wlevel", 32'(bus.wlevel), 32'd8);

        // Reset mid-operation while full with winc high
        @(negedge wclk);
        wrst_n       = 1'b0;
        bus.wq2_rptr = 4'b0000;
        @(posedge wclk);
        #1;
        chk("rst2.wptr", 32'(bus.wptr), 32'd0);
        chk("rst2.wen", 32'(bus.wen), 32'd1);
        chk("rst2.wovf", 32'(bus.woverflow), 32'd0);

        // Wrap: read pointer trails by two, 16 writes walk the full pointer space
        @(negedge wclk);
        wrst_n = 1'b1;
        mb     = 4'd0;
        for (int i = 0; i < 16; i++) begin
            bus.wq2_rptr = gray(mb - 4'd2);
            bus.winc     = 1'b1;
            #1;
            chk($sformatf("wrap%0d.waddr", i), 32'(bus.waddr), 32'(mb[2:0]));
            chk($sformatf("wrap%0d.wfull", i), 32'(bus.wfull), 32'd0);
            chk($sformatf("wrap%0d.wlevel", i), 32'(bus.wlevel), 32'd2);
            prev = bus.wptr;
            @(posedge wclk);
            #1;
            chk($sformatf("wrap%0d.bits", i), 32'($countones(bus.wptr ^ prev)), 32'd1);
            mb = mb + 4'd1;
            @(negedge wclk);
        end
        chk("wrap.wptr_end", 32'(bus.wptr), 32'd0);

        // Three writes, then a reset pulse that never spans a rising edge
        bus.wq2_rptr = 4'b0000;
        repeat (3) @(posedge wclk);
        @(negedge wclk);
        bus.winc = 1'b0;
        #1;
        wrst_n = 1'b0;
        #2;
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        chk("glitch.waddr", 32'(bus.waddr), 32'd3);
        chk("glitch.wptr", 32'(bus.wptr), 32'(4'b0010));
        chk("glitch.wlevel", 32'(bus.wlevel), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
